// File: rtl/mil1553_bus_arbiter.sv
// mil1553_bus_arbiter: round-robin share of one 1553 transceiver; 1-cycle grant and tx latency,
// idle holdoff after every release, timeout lockout. MIL1553_ARB_ECHO_BLANK_EN blanks rx self-echo.
module mil1553_bus_arbiter #(
  parameter int channels       = 2,
  parameter int holdoff_cycles = 8,
  parameter int timeout_cycles = 1400
) (
  input  logic                aclk,
  input  logic                arstn,
  input  logic [channels-1:0] req,
  output logic [channels-1:0] gnt,
  input  logic [channels-1:0] tx0_in,
  input  logic [channels-1:0] tx1_in,
  input  logic [channels-1:0] en_tx_in,
  output logic [channels-1:0] rx0_out,
  output logic [channels-1:0] rx1_out,
  input  logic [channels-1:0] fault_clr,
  output logic [channels-1:0] fault,
  output logic                busy,
  output logic                tx0_1553,
  output logic                tx1_1553,
  output logic                en_tx_1553,
  input  logic                rx0_1553,
  input  logic                rx1_1553
);
  localparam int MAXC = (holdoff_cycles > timeout_cycles) ? holdoff_cycles : timeout_cycles;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int PW   = (channels > 1) ? $clog2(channels) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(timeout_cycles - 1);
  localparam logic [CW-1:0] HO_LAST = CW'(holdoff_cycles - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  state_t              r_state;
  logic [channels-1:0] r_gnt;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_gidx;
  logic [CW-1:0]       r_cnt;
  logic [channels-1:0] r_fault;
  logic                r_busy;
  logic                r_tx0;
  logic                r_tx1;
  logic                r_en;
  logic                r_rx0;
  logic                r_rx1;

  state_t              w_state_nxt;
  logic [channels-1:0] w_gnt_nxt;
  logic [PW-1:0]       w_ptr_nxt;
  logic [PW-1:0]       w_gidx_nxt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [channels-1:0] w_fault_set;
  logic                w_tx0_nxt;
  logic                w_tx1_nxt;
  logic                w_en_nxt;
  logic [channels-1:0] w_elig;
  logic                w_hit;
  logic [PW-1:0]       w_hit_idx;
  logic [PW-1:0]       w_scan_idx;
  int                  w_scan;
  logic                w_blank;
  state_t              w_release_state;

  // Round-robin scan of the eligible set, starting at the pointer and wrapping.
  always_comb begin
    w_elig     = req & ~r_fault;
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_scan     = 0;
    w_scan_idx = '0;
    for (int i = 0; i < channels; i++) begin
      w_scan     = (int'(r_ptr) + i) % channels;
      w_scan_idx = PW'(w_scan);
      if (!w_hit && w_elig[w_scan_idx]) begin
        w_hit     = 1'b1;
        w_hit_idx = w_scan_idx;
      end
    end
  end

  assign w_release_state = (holdoff_cycles == 0) ? S_IDLE : S_HOLDOFF;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_gidx_nxt  = r_gidx;
    w_cnt_nxt   = r_cnt;
    w_fault_set = '0;
    w_tx0_nxt   = 1'b0;
    w_tx1_nxt   = 1'b0;
    w_en_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          w_state_nxt            = S_GRANT;
          w_gnt_nxt              = '0;
          w_gnt_nxt[w_hit_idx]   = 1'b1;
          w_gidx_nxt             = w_hit_idx;
          w_ptr_nxt              = (channels > 1) ? PW'((int'(w_hit_idx) + 1) % channels) : '0;
          w_cnt_nxt              = '0;
        end
      end
      S_GRANT: begin
        // A request drop on the timeout cycle is a clean release, so it is tested first.
        if (!req[r_gidx]) begin
          w_state_nxt = w_release_state;
          w_gnt_nxt   = '0;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt         = w_release_state;
          w_gnt_nxt           = '0;
          w_cnt_nxt           = '0;
          w_fault_set[r_gidx] = 1'b1;
        end else begin
          w_tx0_nxt = tx0_in[r_gidx];
          w_tx1_nxt = tx1_in[r_gidx];
          w_en_nxt  = en_tx_in[r_gidx];
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_HOLDOFF: begin
        if (r_cnt == HO_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_gidx  <= '0;
      r_cnt   <= '0;
      r_fault <= '0;
      r_busy  <= 1'b0;
      r_tx0   <= 1'b0;
      r_tx1   <= 1'b0;
      r_en    <= 1'b0;
      r_rx0   <= 1'b0;
      r_rx1   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gidx  <= w_gidx_nxt;
      r_cnt   <= w_cnt_nxt;
      // Set dominates a coincident clear.
      r_fault <= (r_fault & ~fault_clr) | w_fault_set;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_tx0   <= w_tx0_nxt;
      r_tx1   <= w_tx1_nxt;
      r_en    <= w_en_nxt;
      r_rx0   <= rx0_1553;
      r_rx1   <= rx1_1553;
    end
  end

`ifdef MIL1553_ARB_ECHO_BLANK_EN
  assign w_blank = (r_state == S_HOLDOFF) || ((r_state == S_GRANT) && r_en);
`else
  assign w_blank = 1'b0;
`endif

  assign rx0_out    = {channels{r_rx0 & ~w_blank}};
  assign rx1_out    = {channels{r_rx1 & ~w_blank}};
  assign gnt        = r_gnt;
  assign fault      = r_fault;
  assign busy       = r_busy;
  assign tx0_1553   = r_tx0;
  assign tx1_1553   = r_tx1;
  assign en_tx_1553 = r_en;

endmodule
